// File: rtl/canvas_ws2812_tx_if.sv
// Pixel-fetch and serial-output bundle between the WS2812 transmitter and its host/pixel RAM.
// master = transmitter side, slave = host and pixel buffer side.
interface canvas_ws2812_tx_if #(
  parameter int AW = 6
);
  logic          start;
  logic          busy;
  logic          pix_rd;
  logic [AW-1:0] pix_addr;
  logic [23:0]   pix_data;
  logic          dout;
  logic          frame_done;

  modport master (
    input  start, pix_data,
    output busy, pix_rd, pix_addr, dout, frame_done
  );

  modport slave (
    output start, pix_data,
    input  busy, pix_rd, pix_addr, dout, frame_done
  );
endinterface

// File: rtl/canvas_ws2812_tx.sv
// WS2812 frame transmitter: fetches NUM_PIXELS GRB words from a sync RAM and
// serialises them MSB-first on one pin, followed by a low latch period.
module canvas_ws2812_tx #(
  parameter int NUM_PIXELS   = 64,
  parameter int T0H          = 14,
  parameter int T1H          = 28,
  parameter int T_BIT        = 50,
  parameter int RESET_CYCLES = 2400,
  parameter int AW           = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
  input  logic                wb_clk_i,
  input  logic                rst_n,
  canvas_ws2812_tx_if.master  bus
);

  localparam int CMAX = (T_BIT > RESET_CYCLES) ? T_BIT : RESET_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] BIT_LAST   = CW'(T_BIT - 1);
  localparam logic [CW-1:0] LATCH_LAST = CW'(RESET_CYCLES - 1);
  localparam logic [AW-1:0] ADDR_LAST  = AW'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SEND,
    S_LATCH
  } state_t;

  state_t        state;
  logic          busy_r;
  logic          pix_rd_r;
  logic [AW-1:0] addr_r;
  logic          dout_r;
  logic          done_r;
  logic [23:0]   shreg;
  logic [4:0]    bitcnt;
  logic [CW-1:0] cyc;

  // Line level for bit-period position c when the bit being sent is b.
  function automatic logic high_phase(input logic [CW-1:0] c, input logic b);
    if (b) return (c < CW'(T1H));
    else   return (c < CW'(T0H));
  endfunction

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      busy_r   <= 1'b0;
      pix_rd_r <= 1'b0;
      addr_r   <= '0;
      dout_r   <= 1'b0;
      done_r   <= 1'b0;
      shreg    <= '0;
      bitcnt   <= '0;
      cyc      <= '0;
    end else begin
      pix_rd_r <= 1'b0;
      done_r   <= 1'b0;
      case (state)
        S_IDLE: begin
          dout_r <= 1'b0;
          if (bus.start) begin
            state    <= S_FETCH;
            addr_r   <= '0;
            busy_r   <= 1'b1;
            pix_rd_r <= 1'b1;
          end
        end

        S_FETCH: state <= S_LOAD;

        S_LOAD: begin
          shreg  <= bus.pix_data;
          bitcnt <= 5'd23;
          cyc    <= '0;
          dout_r <= high_phase('0, bus.pix_data[23]);
          state  <= S_SEND;
        end

        S_SEND: begin
          if (cyc == BIT_LAST) begin
            cyc <= '0;
            if (bitcnt != 5'd0) begin
              shreg  <= {shreg[22:0], 1'b0};
              bitcnt <= bitcnt - 5'd1;
              dout_r <= high_phase('0, shreg[22]);
            end else begin
              dout_r <= 1'b0;
              if (addr_r != ADDR_LAST) begin
                addr_r   <= addr_r + AW'(1);
                pix_rd_r <= 1'b1;
                state    <= S_FETCH;
              end else begin
                state <= S_LATCH;
                // A one-cycle latch is simultaneously its own last cycle.
                if (RESET_CYCLES == 1) begin
                  done_r <= 1'b1;
                  busy_r <= 1'b0;
                end
              end
            end
          end else begin
            cyc    <= cyc + CW'(1);
            dout_r <= high_phase(cyc + CW'(1), shreg[23]);
          end
        end

        S_LATCH: begin
          dout_r <= 1'b0;
          if (cyc == LATCH_LAST) begin
            state <= S_IDLE;
          end else begin
            cyc <= cyc + CW'(1);
            // frame_done and busy drop are registered into the final latch cycle.
            if (cyc + CW'(1) == LATCH_LAST) begin
              done_r <= 1'b1;
              busy_r <= 1'b0;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_r;
  assign bus.pix_rd     = pix_rd_r;
  assign bus.pix_addr   = addr_r;
  assign bus.dout       = dout_r;
  assign bus.frame_done = done_r;

endmodule

// File: tb/tb_canvas_ws2812_tx.sv
// Randomized bench for canvas_ws2812_tx against a per-cycle waveform model
// derived from the pixel contents and the WS2812 timing rules.
module tb_canvas_ws2812_tx;

  localparam int NP  = 2;
  localparam int T0H = 2;
  localparam int T1H = 4;
  localparam int TB  = 6;
  localparam int RC  = 10;
  localparam int AW  = 1;
  localparam int PIX = 2 + 24 * TB;
  localparam int FL  = 1 + NP * PIX + RC;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  logic [23:0] ram [NP];

  canvas_ws2812_tx_if #(.AW(AW)) bus ();

  canvas_ws2812_tx #(
    .NUM_PIXELS  (NP),
    .T0H         (T0H),
    .T1H         (T1H),
    .T_BIT       (TB),
    .RESET_CYCLES(RC),
    .AW          (AW)
  ) dut (
    .wb_clk_i(clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sync RAM; outside the cycle after a read the data bus carries garbage.
  always @(posedge clk) begin
    if (bus.pix_rd) bus.pix_data <= ram[bus.pix_addr];
    else            bus.pix_data <= 24'($urandom);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Expected {busy, frame_done, pix_rd, dout} and read address k cycles after start.
  task automatic model(input int k, output logic [3:0] v, output int a);
    int idx, p, r, b, c;
    logic bitv;
    v = 4'b0000;
    a = 0;
    if (k >= 1 && k <= FL - 2) v[3] = 1'b1;
    if (k == FL - 1) v[2] = 1'b1;
    idx = k - 1;
    if (k >= 1 && idx < NP * PIX) begin
      p = idx / PIX;
      r = idx % PIX;
      a = p;
      if (r == 0) v[1] = 1'b1;
      else if (r >= 2) begin
        b = (r - 2) / TB;
        c = (r - 2) % TB;
        bitv = ram[p][23 - b];
        v[0] = (c < (bitv ? T1H : T0H));
      end
    end
  endtask

  // Called at a negedge: that cycle becomes the start cycle.
  task automatic run_frame(input bit spam, input int abort_k);
    logic [3:0] v;
    int a;
    chk("pre_busy", 32'(bus.busy), 32'd0);
    chk("pre_dout", 32'(bus.dout), 32'd0);
    bus.start = 1'b1;
    for (int k = 1; k <= FL; k++) begin
      @(negedge clk);
      model(k, v, a);
      chk($sformatf("vec@%0d", k),
          32'({bus.busy, bus.frame_done, bus.pix_rd, bus.dout}), 32'(v));
      if (v[1]) chk($sformatf("addr@%0d", k), 32'(bus.pix_addr), 32'(a));
      bus.start = (spam && k < FL) ? 1'b1 : 1'b0;
      if (k == abort_k) begin
        bus.start = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_dout", 32'(bus.dout), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_rd",   32'(bus.pix_rd), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < NP; i++) ram[i] = 24'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    for (int i = 0; i < NP; i++) ram[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", 32'({bus.busy, bus.frame_done, bus.pix_rd, bus.dout, bus.pix_addr}), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("idle@%0d", i),
          32'({bus.busy, bus.frame_done, bus.pix_rd, bus.dout, bus.pix_addr}), 32'd0);
    end

    // Directed pattern with mixed 0/1 bits and a lone trailing '1'.
    ram[0] = 24'hA50000;
    ram[1] = 24'h000001;
    run_frame(1'b0, 0);
    repeat (3) @(negedge clk);

    // Start held high for a whole frame, then a fresh start right after frame_done.
    fill_random();
    run_frame(1'b1, 0);
    run_frame(1'b0, 0);
    @(negedge clk);

    // Reset while pixel 0 bit 5 is driving high, then a full frame from pixel 0.
    ram[0] = 24'hA50000;
    ram[1] = 24'h000001;
    run_frame(1'b0, 3 + 5 * TB);
    run_frame(1'b0, 0);
    @(negedge clk);

    // All ones: every bit high T1H, low T_BIT-T1H.
    ram[0] = 24'hFFFFFF;
    ram[1] = 24'hFFFFFF;
    run_frame(1'b0, 0);

    for (int n = 0; n < 5; n++) begin
      fill_random();
      repeat ($urandom_range(0, 4)) begin
        @(negedge clk);
        chk("gap_busy", 32'(bus.busy), 32'd0);
      end
      run_frame(1'($urandom_range(0, 1)), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
